mult_sched: RTL and testbench



---
 rtl/mult_sched.sv | 145 ++++++++++++++
 tb/tb_mult_sched.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one external combinational multiplier.
// Optional MULT_SCHED_ZERO_BYPASS_EN: zero operands skip the multiplier.
module mult_sched #(
  parameter int INPUT_SIZE  = 160,
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 2,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW  = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*INPUT_SIZE-1:0] req_op1,
  input  logic [NUM_REQ*INPUT_SIZE-1:0] req_op2,
  output logic [INPUT_SIZE-1:0]         mul_op1,
  output logic [INPUT_SIZE-1:0]         mul_op2,
  input  logic [2*INPUT_SIZE-1:0]       mul_product,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [2*INPUT_SIZE-1:0]       resp_product,
  output logic [IDW-1:0]                resp_id
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [IDW-1:0]        rr_ptr;
  logic [IDW-1:0]        grant;
  logic                  found;
  logic [CW-1:0]         cnt;
  logic [INPUT_SIZE-1:0] g_op1;
  logic [INPUT_SIZE-1:0] g_op2;
  logic                  accept;
  logic                  bypass;
  logic                  done;

  function automatic logic [IDW-1:0] wrap_idx(
    input logic [IDW-1:0] base,
    input int             k
  );
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // Scan downward so the closest valid requester to rr_ptr wins last.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(rr_ptr, k)]) begin
        found = 1'b1;
        grant = wrap_idx(rr_ptr, k);
      end
    end
  end

  assign g_op1 = req_op1[grant*INPUT_SIZE +: INPUT_SIZE];
  assign g_op2 = req_op2[grant*INPUT_SIZE +: INPUT_SIZE];

`ifdef MULT_SCHED_ZERO_BYPASS_EN
  assign bypass = (g_op1 == '0) || (g_op2 == '0);
`else
  assign bypass = 1'b0;
`endif

  assign accept = (state_q == IDLE) && found && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;
    end
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (accept) state_d = bypass ? RESP : EXEC;
      end
      (state_q == EXEC): begin
        if (cnt == '0) state_d = RESP;
      end
      (state_q == RESP): begin
        if (resp_ready) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      cnt          <= '0;
      mul_op1      <= '0;
      mul_op2      <= '0;
      resp_valid   <= 1'b0;
      resp_product <= '0;
      resp_id      <= '0;
    end else begin
      if (accept) begin
        resp_id <= grant;
        if (bypass) begin
          resp_product <= '0;
          resp_valid   <= 1'b1;
        end else begin
          mul_op1 <= g_op1;
          mul_op2 <= g_op2;
          cnt     <= CW'(MUL_LATENCY - 1);
        end
      end
      if (state_q == EXEC) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          resp_product <= mul_product;
          resp_valid   <= 1'b1;
        end
      end
      // Pointer moves only once the consumer has taken the result.
      if (done) begin
        resp_valid <= 1'b0;
        rr_ptr     <= (resp_id == IDW'(NUM_REQ - 1)) ? '0 : resp_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched with a behavioural 8x8 multiplier.
// Honours MULT_SCHED_ZERO_BYPASS_EN for the zero-operand latency.
module tb_mult_sched;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int ML = 2;
`ifdef MULT_SCHED_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = ML + 1;
`endif

  typedef struct {
    logic [1:0]  id;
    logic [15:0] prod;
    int          acc;
  } exp_t;

  typedef struct {
    logic [3:0]  rdy;
    logic        hs_req;
    logic [1:0]  gid;
    logic [1:0]  mg;
    logic        hs_resp;
    logic        rv;
    logic [1:0]  rid;
    logic [15:0] rprod;
    int          c;
  } obs_t;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*W-1:0] req_op1;
  logic [N*W-1:0] req_op2;
  logic [W-1:0]  mul_op1;
  logic [W-1:0]  mul_op2;
  logic [2*W-1:0] mul_product;
  logic          resp_valid;
  logic          resp_ready;
  logic [2*W-1:0] resp_product;
  logic [1:0]    resp_id;

  int   cyc = 0;
  int   n_cmp;
  int   n_err;
  int   mptr;
  int   rise_cyc;
  logic prev_rv;
  exp_t sbq[$];

  mult_sched #(
    .INPUT_SIZE (W),
    .NUM_REQ    (N),
    .MUL_LATENCY(ML)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .mul_op1     (mul_op1),
    .mul_op2     (mul_op2),
    .mul_product (mul_product),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_product(resp_product),
    .resp_id     (resp_id)
  );

  assign mul_product = 16'(mul_op1) * 16'(mul_op2);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One cycle: observe handshakes, push expectations, advance to next negedge.
  task automatic tick(output obs_t o);
    logic [7:0] a;
    logic [7:0] b;
    exp_t e;
    #1;
    o.c       = cyc;
    o.rdy     = req_ready;
    o.rv      = resp_valid;
    o.rid     = resp_id;
    o.rprod   = resp_product;
    o.hs_resp = resp_valid && resp_ready;
    o.hs_req  = |(req_valid & req_ready);
    o.gid     = 2'd0;
    for (int i = 0; i < N; i++) if (req_ready[i]) o.gid = 2'(i);
    o.mg = 2'(mptr);
    for (int k = N - 1; k >= 0; k--)
      if (req_valid[(mptr + k) % N]) o.mg = 2'((mptr + k) % N);
    if (resp_valid && !prev_rv) rise_cyc = cyc;
    prev_rv = resp_valid;
    if (o.hs_resp && sbq.size() > 0) mptr = (int'(sbq[0].id) + 1) % N;
    if (o.hs_req) begin
      a      = req_op1[o.mg*W +: W];
      b      = req_op2[o.mg*W +: W];
      e.id   = o.mg;
      e.prod = 16'(a) * 16'(b);
      e.acc  = cyc;
      sbq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    sbq.delete();
    mptr    = 0;
    prev_rv = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = 4'hF;
    resp_ready = 1'b1;
    req_op1    = 32'h5566_7788;
    req_op2    = 32'h1122_3344;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if ({req_ready, resp_valid, resp_id, resp_product, mul_op1, mul_op2} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got rdy=%b rv=%b id=%0d p=%h m=%h/%h exp all 0",
               req_ready, resp_valid, resp_id, resp_product, mul_op1, mul_op2);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_first_grant got %b exp 0001", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    mptr    = 0;
    prev_rv = 1'b0;
    sbq.delete();
  endtask

  task automatic test_single();
    obs_t o;
    exp_t e;
    bit   done = 0;
    req_op1[1*W +: W] = 8'hFF;
    req_op2[1*W +: W] = 8'hFF;
    req_valid  = 4'b0010;
    resp_ready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      tick(o);
      if (o.hs_req) begin
        req_valid = '0;
        n_cmp++;
        if (o.gid !== 2'd1) begin
          n_err++;
          $display("FAIL single_grant got %0d exp 1", o.gid);
        end
      end
      if (o.hs_resp && sbq.size() > 0) begin
        e    = sbq.pop_front();
        done = 1;
        n_cmp++;
        if (o.rprod !== 16'hFE01) begin
          n_err++;
          $display("FAIL single_prod got %h exp fe01", o.rprod);
        end
        n_cmp++;
        if (o.rid !== e.id) begin
          n_err++;
          $display("FAIL single_id got %0d exp %0d", o.rid, e.id);
        end
        n_cmp++;
        if (rise_cyc - e.acc !== ML + 1) begin
          n_err++;
          $display("FAIL single_latency got %0d exp %0d", rise_cyc - e.acc, ML + 1);
        end
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL single_timeout got no response exp one");
    end
  endtask

  task automatic test_round_robin();
    obs_t o;
    exp_t e;
    int   ord[5] = '{0, 1, 2, 3, 0};
    int   ng = 0;
    int   nr = 0;
    int   lastg = 0;
    for (int i = 0; i < N; i++) begin
      req_op1[i*W +: W] = 8'(i + 2);
      req_op2[i*W +: W] = 8'h10;
    end
    req_valid  = 4'hF;
    resp_ready = 1'b1;
    for (int c = 0; c < 100 && nr < 5; c++) begin
      tick(o);
      if (o.hs_req && ng < 5) begin
        n_cmp++;
        if (o.rdy !== 4'(1 << ord[ng])) begin
          n_err++;
          $display("FAIL rr_grant%0d got %b exp idx %0d", ng, o.rdy, ord[ng]);
        end
        if (ng > 0) begin
          n_cmp++;
          if (o.c - lastg !== ML + 2) begin
            n_err++;
            $display("FAIL rr_spacing%0d got %0d exp %0d", ng, o.c - lastg, ML + 2);
          end
        end
        lastg = o.c;
        ng++;
        if (ng == 5) req_valid = '0;
      end
      if (o.hs_resp && sbq.size() > 0) begin
        e = sbq.pop_front();
        n_cmp++;
        if (o.rprod !== e.prod || o.rid !== e.id) begin
          n_err++;
          $display("FAIL rr_resp%0d got id=%0d p=%h exp id=%0d p=%h",
                   nr, o.rid, o.rprod, e.id, e.prod);
        end
        nr++;
      end
    end
    n_cmp++;
    if (nr != 5) begin
      n_err++;
      $display("FAIL rr_timeout got %0d responses exp 5", nr);
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    exp_t e;
    bit   done = 0;
    req_op1[3*W +: W] = 8'h07;
    req_op2[3*W +: W] = 8'h09;
    req_op1[0*W +: W] = 8'h0B;
    req_op2[0*W +: W] = 8'h02;
    req_valid  = 4'b1000;
    resp_ready = 1'b0;
    for (int c = 0; c < 20 && resp_valid !== 1'b1; c++) begin
      tick(o);
      if (o.hs_req) req_valid = 4'b0001;
    end
    n_cmp++;
    if (resp_valid !== 1'b1 || sbq.size() == 0) begin
      n_err++;
      $display("FAIL bp_timeout got rv=%b q=%0d exp rv=1", resp_valid, sbq.size());
      return;
    end
    for (int k = 0; k < 10; k++) begin
      tick(o);
      n_cmp++;
      if (o.rv !== 1'b1 || o.rid !== sbq[0].id || o.rprod !== sbq[0].prod) begin
        n_err++;
        $display("FAIL bp_hold%0d got rv=%b id=%0d p=%h exp rv=1 id=%0d p=%h",
                 k, o.rv, o.rid, o.rprod, sbq[0].id, sbq[0].prod);
      end
      n_cmp++;
      if (o.rdy !== 4'b0000) begin
        n_err++;
        $display("FAIL bp_ready%0d got %b exp 0000", k, o.rdy);
      end
    end
    resp_ready = 1'b1;
    tick(o);
    n_cmp++;
    if (o.hs_resp !== 1'b1 || sbq.size() == 0) begin
      n_err++;
      $display("FAIL bp_complete got hs=%b exp 1", o.hs_resp);
    end else begin
      e = sbq.pop_front();
      n_cmp++;
      if (o.rprod !== 16'h003F || o.rid !== 2'd3) begin
        n_err++;
        $display("FAIL bp_resp got id=%0d p=%h exp id=3 p=003f", o.rid, o.rprod);
      end
      n_cmp++;
      if (rise_cyc - e.acc !== ML + 1) begin
        n_err++;
        $display("FAIL bp_latency got %0d exp %0d", rise_cyc - e.acc, ML + 1);
      end
    end
    for (int c = 0; c < 20 && !done; c++) begin
      tick(o);
      if (o.hs_req) begin
        req_valid = '0;
        n_cmp++;
        if (o.gid !== 2'd0) begin
          n_err++;
          $display("FAIL bp_next_grant got %0d exp 0", o.gid);
        end
      end
      if (o.hs_resp && sbq.size() > 0) begin
        e    = sbq.pop_front();
        done = 1;
        n_cmp++;
        if (o.rprod !== e.prod || o.rid !== e.id) begin
          n_err++;
          $display("FAIL bp_next_resp got id=%0d p=%h exp id=%0d p=%h",
                   o.rid, o.rprod, e.id, e.prod);
        end
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL bp_next_timeout got no response exp one");
    end
  endtask

  task automatic test_operand_change();
    obs_t o;
    exp_t e;
    bit   done = 0;
    req_op1[2*W +: W] = 8'h12;
    req_op2[2*W +: W] = 8'h03;
    req_valid  = 4'b0100;
    resp_ready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      tick(o);
      if (o.hs_req) begin
        req_valid = '0;
        req_op1[2*W +: W] = 8'h34;
      end
      if (o.hs_resp && sbq.size() > 0) begin
        e    = sbq.pop_front();
        done = 1;
        n_cmp++;
        if (o.rprod !== 16'h0036 || o.rid !== 2'd2) begin
          n_err++;
          $display("FAIL opchg_resp got id=%0d p=%h exp id=2 p=0036", o.rid, o.rprod);
        end
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL opchg_timeout got no response exp one");
    end
  endtask

  task automatic test_reset_exec();
    obs_t o;
    exp_t e;
    bit   acc = 0;
    bit   done = 0;
    req_op1[3*W +: W] = 8'h05;
    req_op2[3*W +: W] = 8'h05;
    req_op1[1*W +: W] = 8'h02;
    req_op2[1*W +: W] = 8'h03;
    req_valid  = 4'b1000;
    resp_ready = 1'b1;
    for (int c = 0; c < 20 && !acc; c++) begin
      tick(o);
      if (o.hs_req) acc = 1;
    end
    n_cmp++;
    if (!acc) begin
      n_err++;
      $display("FAIL rstx_accept got none exp grant");
    end
    req_valid = 4'b1010;
    rst       = 1'b1;
    tick(o);
    n_cmp++;
    if (o.rdy !== 4'b0000 || o.rv !== 1'b0) begin
      n_err++;
      $display("FAIL rstx_in_reset got rdy=%b rv=%b exp 0000/0", o.rdy, o.rv);
    end
    rst     = 1'b0;
    sbq.delete();
    mptr    = 0;
    prev_rv = 1'b0;
    n_cmp++;
    if ({resp_valid, resp_id, resp_product, mul_op1, mul_op2} !== '0) begin
      n_err++;
      $display("FAIL rstx_values got rv=%b id=%0d p=%h m=%h/%h exp all 0",
               resp_valid, resp_id, resp_product, mul_op1, mul_op2);
    end
    tick(o);
    req_valid = '0;
    n_cmp++;
    if (o.rdy !== 4'b0010) begin
      n_err++;
      $display("FAIL rstx_grant got %b exp 0010", o.rdy);
    end
    for (int c = 0; c < 20 && !done; c++) begin
      tick(o);
      if (o.hs_resp && sbq.size() > 0) begin
        e    = sbq.pop_front();
        done = 1;
        n_cmp++;
        if (o.rprod !== 16'h0006 || o.rid !== 2'd1) begin
          n_err++;
          $display("FAIL rstx_resp got id=%0d p=%h exp id=1 p=0006", o.rid, o.rprod);
        end
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL rstx_timeout got no response exp one");
    end
  endtask

  task automatic test_zero_operand();
    obs_t o;
    exp_t e;
    bit   done = 0;
    req_op1[0*W +: W] = 8'h00;
    req_op2[0*W +: W] = 8'hAB;
    req_valid  = 4'b0001;
    resp_ready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      tick(o);
      if (o.hs_req) req_valid = '0;
      if (o.hs_resp && sbq.size() > 0) begin
        e    = sbq.pop_front();
        done = 1;
        n_cmp++;
        if (o.rprod !== 16'h0000 || o.rid !== 2'd0) begin
          n_err++;
          $display("FAIL zero_resp got id=%0d p=%h exp id=0 p=0000", o.rid, o.rprod);
        end
        n_cmp++;
        if (rise_cyc - e.acc !== ZLAT) begin
          n_err++;
          $display("FAIL zero_latency got %0d exp %0d", rise_cyc - e.acc, ZLAT);
        end
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL zero_timeout got no response exp one");
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    mptr       = 0;
    rise_cyc   = 0;
    prev_rv    = 1'b0;
    rst        = 1'b1;
    req_valid  = '0;
    req_op1    = '0;
    req_op2    = '0;
    resp_ready = 1'b0;
    test_reset();
    test_single();
    do_reset();
    test_round_robin();
    test_backpressure();
    test_operand_change();
    test_reset_exec();
    test_zero_operand();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
